// File: rtl/rv64_rf_adder_pkg.sv
// Shared constants and types for the RV64 datapath core (register file + adder).
package rv64_core_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef logic [XLEN-1:0] xlen_t;
    typedef logic [AW-1:0]   regaddr_t;

    localparam regaddr_t REG_ZERO = '0;

endpackage

// File: rtl/rv64_rf_adder_if.sv
// Register-file read/write ports plus adder operands and sum, bundled for the datapath core.
interface rv64_rf_adder_if;
    import rv64_core_pkg::*;

    regaddr_t raddr1;
    xlen_t    rdata1;
    regaddr_t raddr2;
    xlen_t    rdata2;
    logic     we;
    regaddr_t waddr;
    xlen_t    wdata;
    xlen_t    src1;
    xlen_t    src2;
    xlen_t    result;

    modport master (
        output raddr1, raddr2, we, waddr, wdata, src1, src2,
        input  rdata1, rdata2, result
    );

    modport slave (
        input  raddr1, raddr2, we, waddr, wdata, src1, src2,
        output rdata1, rdata2, result
    );

endinterface

// File: rtl/rv64_add64.sv
// Pure combinational XLEN-bit adder; the carry-out is dropped so signed and unsigned sums share bits.
module rv64_add64
    import rv64_core_pkg::*;
(
    input  xlen_t a,
    input  xlen_t b,
    output xlen_t sum
);

    assign sum = a + b;

endmodule

// File: rtl/rv64_rf_adder.sv
// RV64 datapath core: 31 stored registers (x0 hardwired to zero), two combinational read ports,
// one synchronous write port, and an independent adder. Optional forwarding: RV64_RF_BYPASS_EN.
module rv64_rf_adder
    import rv64_core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    rv64_rf_adder_if.slave  bus
);

    xlen_t regs [1:NREGS-1];
    logic  write_ok;
    logic  fwd1;
    logic  fwd2;

    assign write_ok = bus.we && (bus.waddr != REG_ZERO);

    // Reset wins over a coincident write, so the clearing edge always leaves every register at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

`ifdef RV64_RF_BYPASS_EN
    assign fwd1 = write_ok && !rst && (bus.raddr1 == bus.waddr);
    assign fwd2 = write_ok && !rst && (bus.raddr2 == bus.waddr);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    always_comb begin
        bus.rdata1 = '0;
        if (bus.raddr1 != REG_ZERO) begin
            bus.rdata1 = fwd1 ? bus.wdata : regs[bus.raddr1];
        end
    end

    always_comb begin
        bus.rdata2 = '0;
        if (bus.raddr2 != REG_ZERO) begin
            bus.rdata2 = fwd2 ? bus.wdata : regs[bus.raddr2];
        end
    end

    rv64_add64 u_add (
        .a   (bus.src1),
        .b   (bus.src2),
        .sum (bus.result)
    );

endmodule

// File: tb/tb_rv64_rf_adder.sv
// Directed self-checking bench for rv64_rf_adder; expectations follow RV64_RF_BYPASS_EN when defined.
module tb_rv64_rf_adder;
    import rv64_core_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    rv64_rf_adder_if bus ();

    rv64_rf_adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_reg(input regaddr_t addr, input xlen_t data);
        @(negedge clk);
        bus.we    = 1'b1;
        bus.waddr = addr;
        bus.wdata = data;
        @(negedge clk);
        bus.we    = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        bus.we = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            bus.raddr1 = regaddr_t'(i);
            bus.raddr2 = regaddr_t'(NREGS - 1 - i);
            #1;
            vectors++;
            if (bus.rdata1 !== 64'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_rd1 addr=%0d got=%h want=0", i, bus.rdata1);
            end
            vectors++;
            if (bus.rdata2 !== 64'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_rd2 addr=%0d got=%h want=0", NREGS - 1 - i, bus.rdata2);
            end
        end
    endtask

    task automatic test_write_read();
        write_reg(5'd5, 64'h0000_0000_8000_0004);
        bus.raddr1 = 5'd5;
        bus.raddr2 = 5'd5;
        #1;
        vectors++;
        if (bus.rdata1 !== 64'h0000_0000_8000_0004) begin
            miscompares++;
            $display("[TB] FAIL wr_rd1_x5 got=%h want=%h", bus.rdata1, 64'h0000_0000_8000_0004);
        end
        vectors++;
        if (bus.rdata2 !== 64'h0000_0000_8000_0004) begin
            miscompares++;
            $display("[TB] FAIL wr_rd2_x5 got=%h want=%h", bus.rdata2, 64'h0000_0000_8000_0004);
        end
        bus.raddr1 = 5'd6;
        #1;
        vectors++;
        if (bus.rdata1 !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL wr_rd1_x6 got=%h want=0", bus.rdata1);
        end
        write_reg(5'd31, 64'hA5A5_0000_FFFF_1234);
        bus.raddr2 = 5'd31;
        #1;
        vectors++;
        if (bus.rdata2 !== 64'hA5A5_0000_FFFF_1234) begin
            miscompares++;
            $display("[TB] FAIL wr_rd2_x31 got=%h want=%h", bus.rdata2, 64'hA5A5_0000_FFFF_1234);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        bus.we     = 1'b1;
        bus.waddr  = 5'd0;
        bus.wdata  = 64'hDEAD_BEEF_CAFE_F00D;
        bus.raddr1 = 5'd0;
        #1;
        vectors++;
        if (bus.rdata1 !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL x0_during_write got=%h want=0", bus.rdata1);
        end
        @(negedge clk);
        bus.we = 1'b0;
        #1;
        vectors++;
        if (bus.rdata1 !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL x0_after_write got=%h want=0", bus.rdata1);
        end
    endtask

    task automatic test_read_during_write();
        xlen_t want_before;
`ifdef RV64_RF_BYPASS_EN
        want_before = 64'h22;
`else
        want_before = 64'h11;
`endif
        write_reg(5'd7, 64'h11);
        @(negedge clk);
        bus.we     = 1'b1;
        bus.waddr  = 5'd7;
        bus.wdata  = 64'h22;
        bus.raddr1 = 5'd7;
        bus.raddr2 = 5'd5;
        #1;
        vectors++;
        if (bus.rdata1 !== want_before) begin
            miscompares++;
            $display("[TB] FAIL rdw_before_edge got=%h want=%h", bus.rdata1, want_before);
        end
        vectors++;
        if (bus.rdata2 !== 64'h0000_0000_8000_0004) begin
            miscompares++;
            $display("[TB] FAIL rdw_other_port got=%h want=%h", bus.rdata2, 64'h0000_0000_8000_0004);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.rdata1 !== 64'h22) begin
            miscompares++;
            $display("[TB] FAIL rdw_after_edge got=%h want=%h", bus.rdata1, 64'h22);
        end
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic test_reset_priority();
        write_reg(5'd3, 64'h99);
        @(negedge clk);
        rst        = 1'b1;
        bus.we     = 1'b1;
        bus.waddr  = 5'd3;
        bus.wdata  = 64'h55;
        bus.raddr1 = 5'd3;
        bus.src1   = 64'h10;
        bus.src2   = 64'h20;
        #1;
        vectors++;
        if (bus.rdata1 !== 64'h99) begin
            miscompares++;
            $display("[TB] FAIL rstpri_before_edge got=%h want=%h", bus.rdata1, 64'h99);
        end
        vectors++;
        if (bus.result !== 64'h30) begin
            miscompares++;
            $display("[TB] FAIL add_during_rst got=%h want=%h", bus.result, 64'h30);
        end
        @(negedge clk);
        rst    = 1'b0;
        bus.we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            regaddr_t a;
            a = (i == 0) ? 5'd3 : (i == 1) ? 5'd5 : (i == 2) ? 5'd7 : 5'd31;
            bus.raddr1 = a;
            bus.raddr2 = a;
            #1;
            vectors++;
            if (bus.rdata1 !== 64'h0 || bus.rdata2 !== 64'h0) begin
                miscompares++;
                $display("[TB] FAIL rstpri_cleared x%0d got=%h/%h want=0", a, bus.rdata1, bus.rdata2);
            end
        end
    endtask

    task automatic test_adder();
        xlen_t a_tab [4];
        xlen_t b_tab [4];
        xlen_t s_tab [4];
        a_tab = '{64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h7FFF_FFFF_FFFF_FFFF};
        b_tab = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h1,                   64'h20, 64'h1};
        s_tab = '{64'h0000_0000_7FFF_FFFC, 64'h0,                   64'h30, 64'h8000_0000_0000_0000};
        for (int i = 0; i < 4; i++) begin
            bus.src1 = a_tab[i];
            bus.src2 = b_tab[i];
            #1;
            vectors++;
            if (bus.result !== s_tab[i]) begin
                miscompares++;
                $display("[TB] FAIL add_vec%0d got=%h want=%h", i, bus.result, s_tab[i]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.we      = 1'b0;
        bus.waddr   = '0;
        bus.wdata   = '0;
        bus.raddr1  = '0;
        bus.raddr2  = '0;
        bus.src1    = '0;
        bus.src2    = '0;

        test_reset();
        test_write_read();
        test_x0();
        test_read_during_write();
        test_reset_priority();
        test_adder();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
